// File: rtl/iterative_alu_pkg.sv
// iterative_alu_pkg: shared constants for the execute-stage ALU.
//   - 5-bit operation encodings driven on ctrl
//   - FSM state encoding shared by the top and anything observing it
//   - small decode helpers for the iterative (mul/div) operations
package iterative_alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_OR    = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MFHI  = 5'd20;
  localparam logic [4:0] OP_MFLO  = 5'd21;
  localparam logic [4:0] OP_MTHI  = 5'd22;
  localparam logic [4:0] OP_MTLO  = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } state_t;

  function automatic logic op_is_iter(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/iterative_alu_muldiv_core.sv
// muldiv_core: unsigned iterative datapath shared by multiply and divide.
//   clk, reset_n : clock, async active-low reset
//   load         : capture magnitudes and clear the accumulator/counter
//   step         : perform one radix-2 iteration (is_div selects divide)
//   mag_a, mag_b : operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   acc_hi       : product high half / partial remainder
//   acc_lo       : product low half / quotient
//   count        : iterations completed since load
module muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;

  // Multiply: add multiplicand when the current multiplier bit is set,
  // then shift the whole {acc_hi, acc_lo} pair right by one.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

  // Divide: shift the next dividend bit into the partial remainder and keep
  // the trial subtraction only if it does not go negative. The remainder is
  // always below the divisor, so the difference fits in WIDTH bits.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb});
  assign div_sub   = div_shift[WIDTH-1:0] - opb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else if (load) begin
      opb    <= mag_b;
      acc_hi <= '0;
      acc_lo <= mag_a;
      count  <= '0;
    end else if (step) begin
      count <= count + 1'b1;
      if (is_div) begin
        acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: execute-stage ALU with single-cycle ops and iterative
// multiply/divide into HI/LO.
//   clk, reset_n : clock, async active-low reset
//   start, ctrl  : launch operation ctrl (taken only when busy=0)
//   a, b         : operands (b[SHAMT_W-1:0] is the shift amount)
//   busy         : multi-cycle operation in flight
//   done         : one-cycle pulse when out/overflow/hi/lo are valid
//   out/overflow : registered result and signed overflow (add/sub only)
//   hi, lo       : HI/LO registers
//   abort        : only with ITERATIVE_ALU_ABORT_EN; cancels an in-flight op
// Handshake: an op is accepted on a rising edge where start=1 and busy=0.
// Single-cycle ops raise done right after the accept edge with busy=0;
// mul/div hold busy=1 from the accept edge until done, and done rises
// exactly as busy falls. start while busy is ignored.
// Debug: the FSM state is held in the typed signal `state`.
module iterative_alu
  import iterative_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ITERATIVE_ALU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state, state_n;

  logic             abort_req;
  logic             accept, iter_op, sgn, sa, sb;
  logic             load, step, fixup_wr;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [CNT_W-1:0] count;
  logic             last;

  // Operation context captured at accept.
  logic             is_div_q, neg_q_q, neg_r_q, b_zero_q;
  logic [WIDTH-1:0] a_q;

  logic [WIDTH:0]     add_sum, sub_diff;
  logic [WIDTH-1:0]   sc_out;
  logic               sc_ovf;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo, rem;

`ifdef ITERATIVE_ALU_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign busy    = (state != ST_IDLE);
  assign accept  = (state == ST_IDLE) && start;
  assign iter_op = op_is_iter(ctrl);
  assign sgn     = op_is_signed(ctrl);
  assign sa      = sgn & a[WIDTH-1];
  assign sb      = sgn & b[WIDTH-1];
  // The most negative value negates to itself, which is its correct
  // unsigned magnitude, so no extra bit is needed.
  assign mag_a   = sa ? -a : a;
  assign mag_b   = sb ? -b : b;
  assign last    = (count == LAST_CNT);

  muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .is_div  (state == ST_DIV),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    step     = 1'b0;
    fixup_wr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && iter_op) begin
          load    = 1'b1;
          state_n = op_is_div(ctrl) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (abort_req) state_n = ST_IDLE;
        else begin
          step = 1'b1;
          if (last) state_n = ST_FIXUP;
        end
      end
      ST_DIV: begin
        if (abort_req)     state_n = ST_IDLE;
        else if (b_zero_q) state_n = ST_FIXUP;  // divide by zero skips iteration
        else begin
          step = 1'b1;
          if (last) state_n = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        fixup_wr = !abort_req;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Single-cycle datapath; sign-extended WIDTH+1 add/sub exposes overflow.
  assign add_sum  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign sub_diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  always_comb begin
    sc_out = '0;
    sc_ovf = 1'b0;
    case (ctrl)
      OP_ADD:  begin sc_out = add_sum[WIDTH-1:0];  sc_ovf = add_sum[WIDTH] ^ add_sum[WIDTH-1]; end
      OP_SUB:  begin sc_out = sub_diff[WIDTH-1:0]; sc_ovf = sub_diff[WIDTH] ^ sub_diff[WIDTH-1]; end
      OP_OR:   sc_out = a | b;
      OP_AND:  sc_out = a & b;
      OP_XOR:  sc_out = a ^ b;
      OP_NOR:  sc_out = ~(a | b);
      OP_SLL:  sc_out = a << b[SHAMT_W-1:0];
      OP_SRL:  sc_out = a >> b[SHAMT_W-1:0];
      OP_SRA:  sc_out = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
      OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_out = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: sc_out = hi;
      OP_MFLO: sc_out = lo;
      default: sc_out = '0;  // MTHI/MTLO and undefined codes
    endcase
  end

  // Sign fixup applied to the unsigned magnitude result.
  assign prod_mag = {acc_hi, acc_lo};
  assign prod     = neg_q_q ? -prod_mag : prod_mag;
  assign quo      = neg_q_q ? -acc_lo : acc_lo;
  assign rem      = neg_r_q ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done     <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (iter_op) begin
          is_div_q <= op_is_div(ctrl);
          neg_q_q  <= sa ^ sb;
          neg_r_q  <= sa;  // remainder follows the dividend's sign
          b_zero_q <= (b == '0);
          a_q      <= a;
        end else begin
          out      <= sc_out;
          overflow <= sc_ovf;
          done     <= 1'b1;
          if (ctrl == OP_MTHI) hi <= a;
          if (ctrl == OP_MTLO) lo <= a;
        end
      end
      if (fixup_wr) begin
        done <= 1'b1;
        if (!is_div_q) begin
          {hi, lo} <= prod;
        end else if (b_zero_q) begin
          hi <= a_q;
          lo <= '1;
        end else begin
          hi <= rem;
          lo <= quo;
        end
      end
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: self-checking bench for iterative_alu (WIDTH=32).
// Reference model uses plain 64-bit arithmetic on the operation definitions.
module tb_iterative_alu;
  import iterative_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [4:0]   ctrl;
  logic [W-1:0] a, b;
  logic         busy, done, overflow;
  logic [W-1:0] out, hi, lo;
`ifdef ITERATIVE_ALU_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;

  // Model state
  logic [W-1:0] m_out, m_hi, m_lo;
  logic [W-1:0] exp_q[$];
  logic         exp_ov_q[$];

  logic [4:0] sc_ops [17] = '{OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL,
                              OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO,
                              OP_MTHI, OP_MTLO, 5'd11, 5'd27};

  iterative_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .ctrl     (ctrl),
    .a        (a),
    .b        (b),
`ifdef ITERATIVE_ALU_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .out      (out),
    .overflow (overflow),
    .hi       (hi),
    .lo       (lo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_single(input logic [4:0] op, input logic [W-1:0] x, y,
                                       output logic [W-1:0] r, output logic ov);
    longint s;
    r  = '0;
    ov = 1'b0;
    case (op)
      OP_ADD:  begin s = longint'($signed(x)) + longint'($signed(y)); r = s[W-1:0];
                     ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB:  begin s = longint'($signed(x)) - longint'($signed(y)); r = s[W-1:0];
                     ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_SLL:  r = x << y[4:0];
      OP_SRL:  r = x >> y[4:0];
      OP_SRA:  r = $unsigned($signed(x) >>> y[4:0]);
      OP_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      OP_MFHI: r = m_hi;
      OP_MFLO: r = m_lo;
      default: r = '0;
    endcase
  endfunction

  function automatic void model_iter(input logic [4:0] op, input logic [W-1:0] x, y,
                                     output logic [W-1:0] h, output logic [W-1:0] l,
                                     output int lat);
    longint p, q, rr;
    logic [63:0] up;
    lat = 33;
    h = '0;
    l = '0;
    case (op)
      OP_MULT:  begin p = longint'($signed(x)) * longint'($signed(y)); {h, l} = p; end
      OP_MULTU: begin up = {32'd0, x} * {32'd0, y}; {h, l} = up; end
      OP_DIV: begin
        if (y == 0) begin l = '1; h = x; lat = 2; end
        else begin
          q  = longint'($signed(x)) / longint'($signed(y));
          rr = longint'($signed(x)) % longint'($signed(y));
          l  = q[W-1:0];
          h  = rr[W-1:0];
        end
      end
      default: begin
        if (y == 0) begin l = '1; h = x; lat = 2; end
        else begin l = x / y; h = x % y; end
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step_single(input logic [4:0] op, input logic [W-1:0] x, y);
    @(negedge clk);
    ctrl = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Launch a mul/div and observe it; k counts negedges after the accept edge.
  task automatic run_iter(input logic [4:0] op, input logic [W-1:0] x, y, input bit poke,
                          output int done_k, output int busy_cnt, output bit early_bad,
                          output bit busy_at_done, output bit done_after);
    done_k = -1; busy_cnt = 0; early_bad = 1'b0; busy_at_done = 1'b1; done_after = 1'b1;
    @(negedge clk);
    ctrl = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; ctrl = 5'($urandom_range(0, 31));
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (done === 1'b1) begin
        done_k = k;
        busy_at_done = busy;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (hi !== m_hi || lo !== m_lo || out !== m_out) early_bad = 1'b1;
      if (poke && k == 3) begin ctrl = OP_MTHI; a = $urandom; start = 1'b1; end
      if (poke && k == 4) start = 1'b0;
    end
    start = 1'b0;
    if (done_k >= 0) begin
      @(negedge clk);
      done_after = done;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL reset_flags: busy=%b done=%b ovf=%b expected 0 0 0", busy, done, overflow); errors++; end
    checks++;
    if (out !== '0 || hi !== '0 || lo !== '0) begin
      $display("FAIL reset_regs: out=%h hi=%h lo=%h expected zeros", out, hi, lo); errors++; end
    checks++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_directed();
    step_single(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    if (out !== 32'h8000_0000 || overflow !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL add_ovf: out=%h ovf=%b done=%b busy=%b expected 80000000 1 1 0", out, overflow, done, busy); errors++; end
    checks++;
    @(negedge clk);
    if (done !== 1'b0) begin
      $display("FAIL done_pulse: done=%b expected 0", done); errors++; end
    checks++;
    step_single(OP_SUB, 32'h8000_0000, 32'h1);
    if (out !== 32'h7FFF_FFFF || overflow !== 1'b1) begin
      $display("FAIL sub_ovf: out=%h ovf=%b expected 7fffffff 1", out, overflow); errors++; end
    checks++;
    step_single(OP_SRA, 32'h8000_0010, 32'h24);
    if (out !== 32'hF800_0001 || overflow !== 1'b0) begin
      $display("FAIL sra: out=%h ovf=%b expected f8000001 0", out, overflow); errors++; end
    checks++;
    step_single(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    if (out !== 32'h1) begin
      $display("FAIL slt: out=%h expected 1", out); errors++; end
    checks++;
    step_single(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
    if (out !== 32'h0) begin
      $display("FAIL sltu: out=%h expected 0", out); errors++; end
    checks++;
    step_single(5'd14, 32'h1234_5678, 32'h1);
    if (out !== 32'h0 || done !== 1'b1 || overflow !== 1'b0) begin
      $display("FAIL undef_op: out=%h done=%b ovf=%b expected 0 1 0", out, done, overflow); errors++; end
    checks++;
    m_out = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [4:0]   op;
    logic [W-1:0] x, y, r, e;
    logic         ov, eov;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      op = sc_ops[$urandom_range(0, 16)];
      x  = pick_operand();
      y  = ($urandom_range(0, 4) == 0) ? x : pick_operand();
      model_single(op, x, y, r, ov);
      exp_q.push_back(r);
      exp_ov_q.push_back(ov);
      if (op == OP_MTHI) m_hi = x;
      if (op == OP_MTLO) m_lo = x;
      ctrl = op; a = x; b = y; start = 1'b1;
      @(negedge clk);
      e   = exp_q.pop_front();
      eov = exp_ov_q.pop_front();
      if (done !== 1'b1 || busy !== 1'b0) begin
        $display("FAIL b2b_hs op=%0d: done=%b busy=%b expected 1 0", op, done, busy); errors++; end
      checks++;
      if (out !== e || overflow !== eov) begin
        $display("FAIL b2b_result op=%0d a=%h b=%h: out=%h ovf=%b expected %h %b", op, x, y, out, overflow, e, eov); errors++; end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        $display("FAIL b2b_hilo op=%0d: hi=%h lo=%h expected %h %h", op, hi, lo, m_hi, m_lo); errors++; end
      checks++;
      m_out = e;
    end
    start = 1'b0;
  endtask

  task automatic test_iter(input bit do_div);
    logic [4:0]   ops [4];
    logic [W-1:0] xs [4], ys [4];
    logic [4:0]   op;
    logic [W-1:0] x, y, eh, el;
    int lat, dk, bc;
    bit eb, bad, da;
    if (do_div) begin
      ops = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIVU};
      xs  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd100};
      ys  = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3};
    end else begin
      ops = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULTU};
      xs  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
      ys  = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin op = ops[i]; x = xs[i]; y = ys[i]; end
      else begin
        op = do_div ? (($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU)
                    : (($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU);
        x = pick_operand();
        y = pick_operand();
      end
      model_iter(op, x, y, eh, el, lat);
      run_iter(op, x, y, (i == 0), dk, bc, bad, eb, da);
      if (dk !== lat) begin
        $display("FAIL iter_latency op=%0d a=%h b=%h: done at %0d expected %0d", op, x, y, dk, lat); errors++; end
      checks++;
      if (bc !== lat || eb !== 1'b0) begin
        $display("FAIL iter_busy op=%0d: busy cycles %0d busy_at_done %b expected %0d 0", op, bc, eb, lat); errors++; end
      checks++;
      if (bad !== 1'b0) begin
        $display("FAIL iter_hold op=%0d: hi/lo/out changed before done (1) expected 0", op); errors++; end
      checks++;
      if (hi !== eh || lo !== el) begin
        $display("FAIL iter_result op=%0d a=%h b=%h: hi=%h lo=%h expected %h %h", op, x, y, hi, lo, eh, el); errors++; end
      checks++;
      if (da !== 1'b0) begin
        $display("FAIL iter_done_pulse op=%0d: done=%b one cycle after expected 0", op, da); errors++; end
      checks++;
      m_hi = eh;
      m_lo = el;
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    @(negedge clk);
    ctrl = OP_MULTU; a = $urandom; b = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || out !== '0) begin
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h out=%h expected 0 0 0 0 0", busy, done, hi, lo, out); errors++; end
    checks++;
    m_hi = '0; m_lo = '0; m_out = '0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    if (seen !== 1'b0) begin
      $display("FAIL reset_no_done: activity after reset=%b expected 0", seen); errors++; end
    checks++;
    step_single(OP_MTHI, 32'h1234, 32'h0);
    if (out !== '0 || hi !== 32'h1234) begin
      $display("FAIL mthi: out=%h hi=%h expected 0 1234", out, hi); errors++; end
    checks++;
    step_single(OP_MFHI, $urandom, $urandom);
    if (out !== 32'h1234) begin
      $display("FAIL mfhi: out=%h expected 1234", out); errors++; end
    checks++;
    m_hi = 32'h1234; m_out = 32'h1234;
  endtask

`ifdef ITERATIVE_ALU_ABORT_EN
  task automatic test_abort();
    bit seen;
    @(negedge clk);
    ctrl = OP_DIVU; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL abort_busy: busy=%b done=%b expected 0 0", busy, done); errors++; end
    checks++;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (seen !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      $display("FAIL abort_hilo: done_seen=%b hi=%h lo=%h expected 0 %h %h", seen, hi, lo, m_hi, m_lo); errors++; end
    checks++;
    @(negedge clk);
    ctrl = OP_ADD; a = 32'd2; b = 32'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    if (out !== 32'd5 || done !== 1'b1) begin
      $display("FAIL abort_idle: out=%h done=%b expected 5 1", out, done); errors++; end
    checks++;
    m_out = 32'd5;
  endtask
`endif

  // ---------------- main sequence / report ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; ctrl = '0; a = '0; b = '0;
`ifdef ITERATIVE_ALU_ABORT_EN
    abort = 1'b0;
`endif
    m_out = '0; m_hi = '0; m_lo = '0;
    test_reset();
    test_single_directed();
    test_back_to_back();
    test_iter(1'b0);
    test_iter(1'b1);
    test_reset_mid_op();
`ifdef ITERATIVE_ALU_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
